// File: rtl/alu_issue_if.sv
// Signal bundle between fetch, the alu_issue stage and the combinational ALU.
// The slave modport is the issue stage's view; the master modport is the environment's.
interface alu_issue_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        hold;
  logic [31:0] rs1_num;
  logic [31:0] rs2_num;
  logic [9:0]  alu_op;
  logic        ex_valid;
  logic [31:0] rd_num;
  logic        illegal;

  modport slave (
    input  instr_valid, instr, hold, rd_num,
    output instr_ready, rs1_num, rs2_num, alu_op, ex_valid, illegal
  );

  modport master (
    output instr_valid, instr, hold, rd_num,
    input  instr_ready, rs1_num, rs2_num, alu_op, ex_valid, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM issue stage: decode, register-file read, EX operand register, ALU writeback.
// Define ALU_ISSUE_FWD_EN to forward rd_num to dependent operands instead of stalling one cycle.
module alu_issue #(
  parameter int CNT_W    = 16,
  parameter int RST_REGS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       bus,
  output logic [CNT_W-1:0] retired_cnt
);
  localparam logic [9:0] OP_NOP = 10'd0, OP_AND = 10'd1, OP_SUB = 10'd2, OP_SLL = 10'd3,
                         OP_ADD = 10'd4, OP_SLT = 10'd5, OP_SLTU = 10'd6, OP_XOR = 10'd7,
                         OP_SRL = 10'd8, OP_SRA = 10'd9, OP_OR = 10'd10;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  logic [31:0]        regs [1:31];
  logic [4:0]         ex_rd_p1;
  logic               wb_en;
  logic               xfer;
  logic               raw_stall;
  logic               dec_legal_p0;
  logic [9:0]         dec_op_p0;
  logic [31:0]        rf_a_p0, rf_b_p0, opa_p0, opb_p0;
  logic signed [31:0] imm_sext_p0;
  logic               hit1_p0, hit2_p0;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_a, rs2_a, rd_a;
  logic       is_op;

  assign opcode      = bus.instr[6:0];
  assign rd_a        = bus.instr[11:7];
  assign funct3      = bus.instr[14:12];
  assign rs1_a       = bus.instr[19:15];
  assign rs2_a       = bus.instr[24:20];
  assign funct7      = bus.instr[31:25];
  assign is_op       = (opcode == OPC_OP);
  assign imm_sext_p0 = 32'($signed(bus.instr[31:20]));

  function automatic logic [9:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  // ---- p0: decode ----
  always_comb begin
    dec_legal_p0 = 1'b0;
    dec_op_p0    = OP_NOP;
    if (is_op) begin
      if (funct7 == F7_BASE) begin
        dec_legal_p0 = 1'b1;
        dec_op_p0    = base_op(funct3);
      end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
        dec_legal_p0 = 1'b1;
        dec_op_p0    = OP_SUB;
      end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
        dec_legal_p0 = 1'b1;
        dec_op_p0    = OP_SRA;
      end
    end else if (opcode == OPC_IMM) begin
      case (funct3)
        3'b001: if (funct7 == F7_BASE) begin
          dec_legal_p0 = 1'b1;
          dec_op_p0    = OP_SLL;
        end
        3'b101: if (funct7 == F7_BASE) begin
          dec_legal_p0 = 1'b1;
          dec_op_p0    = OP_SRL;
        end else if (funct7 == F7_ALT) begin
          dec_legal_p0 = 1'b1;
          dec_op_p0    = OP_SRA;
        end
        default: begin
          dec_legal_p0 = 1'b1;
          dec_op_p0    = base_op(funct3);
        end
      endcase
    end
  end

  // Write-through read: a writeback landing this edge is visible to the decoder now.
  always_comb begin
    rf_a_p0 = '0;
    rf_b_p0 = '0;
    if (rs1_a != 5'd0) rf_a_p0 = (wb_en && ex_rd_p1 == rs1_a) ? bus.rd_num : regs[rs1_a];
    if (rs2_a != 5'd0) rf_b_p0 = (wb_en && ex_rd_p1 == rs2_a) ? bus.rd_num : regs[rs2_a];
  end

  assign hit1_p0 = bus.ex_valid && (ex_rd_p1 != 5'd0) && (ex_rd_p1 == rs1_a);
  assign hit2_p0 = bus.ex_valid && (ex_rd_p1 != 5'd0) && (ex_rd_p1 == rs2_a) && is_op;

`ifdef ALU_ISSUE_FWD_EN
  assign raw_stall = 1'b0;
  assign opa_p0    = hit1_p0 ? bus.rd_num : rf_a_p0;
  always_comb begin
    if (is_op)                       opb_p0 = hit2_p0 ? bus.rd_num : rf_b_p0;
    else if (funct3[1:0] == 2'b01)   opb_p0 = {27'd0, rs2_a};
    else                             opb_p0 = imm_sext_p0;
  end
`else
  assign raw_stall = bus.instr_valid && dec_legal_p0 && (hit1_p0 || hit2_p0);
  assign opa_p0    = rf_a_p0;
  always_comb begin
    if (is_op)                       opb_p0 = rf_b_p0;
    else if (funct3[1:0] == 2'b01)   opb_p0 = {27'd0, rs2_a};
    else                             opb_p0 = imm_sext_p0;
  end
`endif

  assign bus.instr_ready = rst_n && !bus.hold && !raw_stall;
  assign xfer            = bus.instr_valid && bus.instr_ready;
  assign wb_en           = bus.ex_valid && !bus.hold && (ex_rd_p1 != 5'd0);

  // ---- p1: EX register toward the ALU ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rs1_num  <= '0;
      bus.rs2_num  <= '0;
      bus.alu_op   <= OP_NOP;
      bus.ex_valid <= 1'b0;
      bus.illegal  <= 1'b0;
      ex_rd_p1     <= '0;
    end else if (!bus.hold) begin
      bus.ex_valid <= xfer && dec_legal_p0;
      bus.alu_op   <= (xfer && dec_legal_p0) ? dec_op_p0 : OP_NOP;
      bus.illegal  <= xfer && !dec_legal_p0;
      if (xfer && dec_legal_p0) begin
        bus.rs1_num <= opa_p0;
        bus.rs2_num <= opb_p0;
        ex_rd_p1    <= rd_a;
      end
    end
  end

  // Writes to x0 still retire, so the count ignores rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         retired_cnt <= '0;
    else if (bus.ex_valid && !bus.hold) retired_cnt <= retired_cnt + CNT_W'(1);
  end

  // ---- writeback: register file, x0 not stored ----
  generate
    if (RST_REGS != 0) begin : g_rf_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
          regs[ex_rd_p1] <= bus.rd_num;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (wb_en) regs[ex_rd_p1] <= bus.rd_num;
      end
    end
  endgenerate
endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue with a register-level instruction model.
module tb_alu_issue;
  // Narrow counter so the random run also exercises wrap-around.
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] retired_cnt;

  alu_issue_if bus ();

  alu_issue #(.CNT_W(CNT_W), .RST_REGS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int          compared = 0, mismatched = 0;
  logic [31:0] mregs [32];
  int unsigned mcnt;
  bit          prev_live;
  logic [4:0]  prev_rd;
  logic [9:0]  last_op;
  logic [31:0] last_a, last_b;

  function automatic logic [31:0] alu_fn(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      10'd1:   return a & b;
      10'd2:   return a - b;
      10'd3:   return a << b[4:0];
      10'd4:   return a + b;
      10'd5:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10'd6:   return (a < b) ? 32'd1 : 32'd0;
      10'd7:   return a ^ b;
      10'd8:   return a >> b[4:0];
      10'd9:   return $unsigned($signed(a) >>> b[4:0]);
      10'd10:  return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.rd_num = alu_fn(bus.alu_op, bus.rs1_num, bus.rs2_num);

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction table: each legal {funct7,funct3} pair listed explicitly.
  function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [9:0] op, output bit uses2);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    op = 10'd0; uses2 = (opc == 7'h33);
    if (opc == 7'h33) begin
      case ({f7, f3})
        10'b0000000_000: op = 10'd4;
        10'b0100000_000: op = 10'd2;
        10'b0000000_001: op = 10'd3;
        10'b0000000_010: op = 10'd5;
        10'b0000000_011: op = 10'd6;
        10'b0000000_100: op = 10'd7;
        10'b0000000_101: op = 10'd8;
        10'b0100000_101: op = 10'd9;
        10'b0000000_110: op = 10'd10;
        10'b0000000_111: op = 10'd1;
        default:         op = 10'd0;
      endcase
    end else if (opc == 7'h13) begin
      case (f3)
        3'd0: op = 10'd4;
        3'd2: op = 10'd5;
        3'd3: op = 10'd6;
        3'd4: op = 10'd7;
        3'd6: op = 10'd10;
        3'd7: op = 10'd1;
        3'd1: op = (f7 == 7'h00) ? 10'd3 : 10'd0;
        default: op = (f7 == 7'h00) ? 10'd8 : (f7 == 7'h20) ? 10'd9 : 10'd0;
      endcase
    end
    legal = (op != 10'd0);
  endfunction

  task automatic issue(input logic [31:0] w);
    bit          legal, uses2;
    logic [9:0]  op;
    logic [31:0] a, b;
    int          waits, exp_waits;
    ref_decode(w, legal, op, uses2);
    a = mregs[w[19:15]];
    if (uses2)                                   b = mregs[w[24:20]];
    else if (w[14:12] == 3'd1 || w[14:12] == 3'd5) b = {27'd0, w[24:20]};
    else                                         b = {{20{w[31]}}, w[31:20]};
    exp_waits = 0;
`ifndef ALU_ISSUE_FWD_EN
    if (legal && prev_live && prev_rd != 5'd0 &&
        (w[19:15] == prev_rd || (uses2 && w[24:20] == prev_rd))) exp_waits = 1;
`endif
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    waits = 0;
    #1;
    while (!bus.instr_ready && waits < 20) begin
      @(negedge clk); #1; waits++;
    end
    compared++;
    if (waits != exp_waits) begin
      mismatched++;
      $display("FAIL stall_cycles instr=%h got %0d want %0d", w, waits, exp_waits);
    end
    @(posedge clk); #1;
    compared++;
    if (bus.ex_valid !== legal || bus.alu_op !== (legal ? op : 10'd0) || bus.illegal !== !legal) begin
      mismatched++;
      $display("FAIL ex_ctrl instr=%h got v=%b op=%0d ill=%b want v=%b op=%0d ill=%b",
               w, bus.ex_valid, bus.alu_op, bus.illegal, legal, legal ? op : 10'd0, !legal);
    end
    if (legal) begin
      compared++;
      if (bus.rs1_num !== a || bus.rs2_num !== b) begin
        mismatched++;
        $display("FAIL operands instr=%h got %h/%h want %h/%h", w, bus.rs1_num, bus.rs2_num, a, b);
      end
      if (w[11:7] != 5'd0) mregs[w[11:7]] = alu_fn(op, a, b);
      mcnt++;
    end
    prev_live = legal;
    prev_rd = w[11:7];
    last_op = op; last_a = a; last_b = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr = $urandom;
      @(posedge clk); #1;
      compared++;
      if (bus.ex_valid !== 1'b0 || bus.alu_op !== 10'd0 || bus.illegal !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_ex got v=%b op=%0d ill=%b want 0/0/0", bus.ex_valid, bus.alu_op, bus.illegal);
      end
    end
    prev_live = 1'b0;
    compared++;
    if (retired_cnt !== CNT_W'(mcnt)) begin
      mismatched++;
      $display("FAIL retired_cnt got %0d want %0d", retired_cnt, CNT_W'(mcnt));
    end
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0; bus.instr = '0; bus.hold = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = 0; prev_live = 1'b0; prev_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (bus.rs1_num !== 32'd0 || bus.rs2_num !== 32'd0 || bus.alu_op !== 10'd0 || bus.ex_valid !== 1'b0 ||
        bus.illegal !== 1'b0 || retired_cnt !== '0 || bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state got %h %h %0d %b %b %0d rdy=%b want all 0",
               bus.rs1_num, bus.rs2_num, bus.alu_op, bus.ex_valid, bus.illegal, retired_cnt, bus.instr_ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    compared++;
    if (bus.instr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_reset got %b want 1", bus.instr_ready);
    end
  endtask

  task automatic test_vectors();
    issue(32'h00500093);
    compared++;
    if (bus.alu_op !== 10'd4 || bus.rs1_num !== 32'd0 || bus.rs2_num !== 32'd5 || bus.ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL addi_vec got op=%0d %h %h v=%b want 4 0 5 1", bus.alu_op, bus.rs1_num, bus.rs2_num, bus.ex_valid);
    end
    issue(32'h00108133);
    compared++;
    if (bus.rs1_num !== 32'd5 || bus.rs2_num !== 32'd5) begin
      mismatched++;
      $display("FAIL add_dep got %h %h want 5 5", bus.rs1_num, bus.rs2_num);
    end
    issue(enc_i(12'd0, 5'd2, 3'd0, 5'd5));
    compared++;
    if (bus.rs1_num !== 32'd10) begin
      mismatched++;
      $display("FAIL x2_value got %h want 10", bus.rs1_num);
    end
    idle(2);
    issue(32'h4010D193);
    compared++;
    if (bus.alu_op !== 10'd9 || bus.rs2_num !== 32'd1) begin
      mismatched++;
      $display("FAIL srai_vec got op=%0d b=%h want 9 1", bus.alu_op, bus.rs2_num);
    end
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1));
    issue(enc_i(12'd31, 5'd1, 3'd1, 5'd1));
    issue(32'h4010D193);
    issue(enc_i(12'd0, 5'd3, 3'd0, 5'd6));
    compared++;
    if (bus.rs1_num !== 32'hC0000000) begin
      mismatched++;
      $display("FAIL sra_result got %h want c0000000", bus.rs1_num);
    end
    idle(1);
  endtask

  task automatic test_illegal_x0();
    int unsigned cnt_before;
    cnt_before = mcnt;
    issue(32'h0000007F);
    compared++;
    if (bus.illegal !== 1'b1 || bus.alu_op !== 10'd0 || bus.ex_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL illegal_vec got ill=%b op=%0d v=%b want 1 0 0", bus.illegal, bus.alu_op, bus.ex_valid);
    end
    idle(1);
    compared++;
    if (mcnt != cnt_before || retired_cnt !== CNT_W'(cnt_before)) begin
      mismatched++;
      $display("FAIL illegal_count got %0d want %0d", retired_cnt, CNT_W'(cnt_before));
    end
    issue(32'h00700013);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4));
    compared++;
    if (bus.rs1_num !== 32'd0 || bus.rs2_num !== 32'd0) begin
      mismatched++;
      $display("FAIL x0_read got %h %h want 0 0", bus.rs1_num, bus.rs2_num);
    end
    issue(enc_i(12'd0, 5'd4, 3'd0, 5'd7));
    compared++;
    if (bus.rs1_num !== 32'd0) begin
      mismatched++;
      $display("FAIL x4_value got %h want 0", bus.rs1_num);
    end
    idle(1);
  endtask

  task automatic test_hold_and_reset();
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.hold = 1'b1; bus.instr_valid = 1'b1; bus.instr = enc_i(12'd1, 5'd0, 3'd0, 5'd9);
      #1;
      compared++;
      if (bus.instr_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_ready got %b want 0", bus.instr_ready);
      end
      @(posedge clk); #1;
      compared++;
      if (bus.ex_valid !== 1'b1 || bus.alu_op !== last_op || bus.rs1_num !== last_a ||
          bus.rs2_num !== last_b || retired_cnt !== CNT_W'(mcnt - 1)) begin
        mismatched++;
        $display("FAIL hold_stable got v=%b op=%0d %h %h cnt=%0d want 1 %0d %h %h %0d",
                 bus.ex_valid, bus.alu_op, bus.rs1_num, bus.rs2_num, retired_cnt,
                 last_op, last_a, last_b, CNT_W'(mcnt - 1));
      end
    end
    @(negedge clk); bus.hold = 1'b0; bus.instr_valid = 1'b0;
    prev_live = 1'b0;
    idle(1);
    issue(enc_i(12'd0, 5'd4, 3'd0, 5'd8));
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd5));
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (bus.rs1_num !== 32'd0 || bus.rs2_num !== 32'd0 || bus.alu_op !== 10'd0 || bus.ex_valid !== 1'b0 ||
        bus.illegal !== 1'b0 || retired_cnt !== '0 || bus.instr_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset got %h %h %0d %b %b %0d rdy=%b want all 0",
               bus.rs1_num, bus.rs2_num, bus.alu_op, bus.ex_valid, bus.illegal, retired_cnt, bus.instr_ready);
    end
    bus.instr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = 0; prev_live = 1'b0;
    issue(enc_i(12'd0, 5'd5, 3'd0, 5'd6));
    issue(enc_i(12'd0, 5'd1, 3'd0, 5'd6));
    idle(1);
  endtask

  task automatic test_random();
    logic [6:0] opc, f7;
    logic [31:0] w;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(9))
        0:       opc = 7'($urandom);
        1,2,3,4: opc = 7'h33;
        default: opc = 7'h13;
      endcase
      case ($urandom_range(9))
        0:       f7 = 7'($urandom);
        1,2,3:   f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      w = {f7, 5'($urandom_range(7)), 5'($urandom_range(7)), 3'($urandom), 5'($urandom_range(7)), opc};
      issue(w);
      if ($urandom_range(9) == 0) idle(1);
    end
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_illegal_x0();
    test_hold_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
